// File: rtl/cpu_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_axi_rd_arbiter
//  Description : Merges the instruction-fetch and data-side AXI read ports onto
//                the single CPU AXI read port, one burst at a time, holding off
//                data reads while any write is still unacknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_axi_rd_arbiter #(
    parameter int MAX_WR_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,

    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,

    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    input  logic        awvalid,
    input  logic        awready,
    input  logic        bvalid,
    input  logic        bready
);

    localparam int c_cnt_w = $clog2(MAX_WR_OUTSTANDING + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_WR_OUTSTANDING);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR_I = 3'd1,
        ST_AR_D = 3'd2,
        ST_R_I  = 3'd3,
        ST_R_D  = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_last_d;
    logic [c_cnt_w-1:0]   r_wr_cnt;
    logic [31:0]          r_araddr;
    logic [7:0]           r_arlen;
    logic [2:0]           r_arsize;
    logic                 r_arvalid;

    logic w_idle;
    logic w_d_ok;
    logic w_grant_d;
    logic w_grant_i;
    logic w_aw_hs;
    logic w_b_hs;
    logic w_r_done;

    // Data wins a tie unless it also won the previous grant.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_d_ok    = d_arvalid & (r_wr_cnt == '0);
    assign w_grant_d = w_idle & w_d_ok & (~i_arvalid | ~r_last_d);
    assign w_grant_i = w_idle & i_arvalid & ~w_grant_d;

    assign w_aw_hs   = awvalid & awready;
    assign w_b_hs    = bvalid & bready;
    assign w_r_done  = rvalid & rready & rlast;

    assign i_arready = w_grant_i;
    assign d_arready = w_grant_d;

    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = r_arsize;
    assign arvalid   = r_arvalid;

    assign rready    = ((r_state == ST_R_I) & i_rready) | ((r_state == ST_R_D) & d_rready);
    assign i_rvalid  = (r_state == ST_R_I) & rvalid;
    assign i_rlast   = (r_state == ST_R_I) & rlast;
    assign d_rvalid  = (r_state == ST_R_D) & rvalid;
    assign d_rlast   = (r_state == ST_R_D) & rlast;
    assign i_rdata   = rdata;
    assign d_rdata   = rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last_d  <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= ST_AR_D;
                        r_araddr  <= d_araddr;
                        r_arlen   <= d_arlen;
                        r_arsize  <= d_arsize;
                        r_arvalid <= 1'b1;
                        r_last_d  <= 1'b1;
                    end else if (w_grant_i) begin
                        r_state   <= ST_AR_I;
                        r_araddr  <= i_araddr;
                        r_arlen   <= i_arlen;
                        r_arsize  <= i_arsize;
                        r_arvalid <= 1'b1;
                        r_last_d  <= 1'b0;
                    end
                end
                ST_AR_I, ST_AR_D: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= (r_state == ST_AR_I) ? ST_R_I : ST_R_D;
                    end
                end
                ST_R_I, ST_R_D: begin
                    if (w_r_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outstanding-write counter saturates at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else if (w_aw_hs && !w_b_hs && (r_wr_cnt != c_cnt_max)) begin
            r_wr_cnt <= r_wr_cnt + c_cnt_one;
        end else if (w_b_hs && !w_aw_hs && (r_wr_cnt != '0)) begin
            r_wr_cnt <= r_wr_cnt - c_cnt_one;
        end
    end

endmodule
`default_nettype wire
